vx_csr_pipe_unit: RTL and testbench

VX_CSR_PIPE_UNIT -- requirements
Module: VX_csr_pipe_unit

---
 rtl/vx_csr_pkg.sv | 71 +++++++
 rtl/vx_csr_bank.sv | 55 +++++
 rtl/vx_csr_pipe_unit.sv | 209 ++++++++++++++++++++
 tb/tb_vx_csr_pipe_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_pkg.sv
// -----------------------------------------------------------------------------
// vx_csr_pkg
//   Shared definitions for the scratch-CSR pipeline unit.
//
//   Contents:
//     csr_op_e       - request opcode encoding (RW / RS / RC / RD)
//     csr_entry_t    - one pipeline slot: {valid, wid, rd, addr_idx, we, err,
//                      old, new_val}
//     csr_apply_op   - computes the value a request would leave in the CSR
//     csr_op_writes  - decides whether an opcode/operand pair writes at all
//
//   Field widths in csr_entry_t are fixed maxima so the struct can live in a
//   package; the top zero-extends warp ids and addresses into them.
// -----------------------------------------------------------------------------
package vx_csr_pkg;

    localparam int CSR_DATA_W = 32;
    localparam int CSR_ADDR_W = 12;
    localparam int CSR_RD_W   = 5;
    // Warp id storage width inside a pipeline entry; covers up to 256 warps.
    localparam int CSR_WID_W  = 8;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2,
        CSR_OP_RD = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic                  valid;
        logic [CSR_WID_W-1:0]  wid;
        logic [CSR_RD_W-1:0]   rd;
        logic [CSR_ADDR_W-1:0] addr_idx;
        logic                  we;
        logic                  err;
        logic [CSR_DATA_W-1:0] old;
        logic [CSR_DATA_W-1:0] new_val;
    } csr_entry_t;

    function automatic logic [CSR_DATA_W-1:0] csr_apply_op(
        input csr_op_e               op,
        input logic [CSR_DATA_W-1:0] old_val,
        input logic [CSR_DATA_W-1:0] operand
    );
        logic [CSR_DATA_W-1:0] res;
        case (op)
            CSR_OP_RW: res = operand;
            CSR_OP_RS: res = old_val | operand;
            CSR_OP_RC: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

    // Set/clear with a zero mask is a pure read and must not write.
    function automatic logic csr_op_writes(
        input csr_op_e               op,
        input logic [CSR_DATA_W-1:0] operand
    );
        logic res;
        case (op)
            CSR_OP_RW: res = 1'b1;
            CSR_OP_RS,
            CSR_OP_RC: res = (operand != '0);
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vx_csr_bank.sv
// -----------------------------------------------------------------------------
// vx_csr_bank
//   Flat storage for all per-warp scratch CSRs (NUM_WARPS*NUM_CSRS words).
//   One asynchronous read port, one synchronous write port. Every word is
//   cleared by the synchronous active-high reset.
//
//   Ports:
//     clk    - clock
//     reset  - synchronous active-high reset, clears all words
//     we     - write enable
//     waddr  - write word index
//     wdata  - write data
//     raddr  - read word index (out-of-range indices read as zero)
//     rdata  - asynchronous read data
// -----------------------------------------------------------------------------
module vx_csr_bank
    import vx_csr_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int DATA_W = CSR_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Requests to unmapped CSRs may form an index past the array end.
    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/vx_csr_pipe_unit.sv
// -----------------------------------------------------------------------------
// vx_csr_pipe_unit
//   Pipelined per-warp scratch-CSR unit. A request reads the old CSR value in
//   its accept cycle, travels through a STAGES-deep pipeline, and commits its
//   write in the cycle its response fires. A stalled response freezes the
//   whole pipeline, write commit included.
//
//   Build option (macro CSR_PIPE_FWD_EN):
//     defined   - old value forwarded from the youngest in-flight writing
//                 entry with the same warp/address; no hazard stall.
//     undefined - no forwarding; a request stalls while a matching writing
//                 entry is still in flight.
//   Both builds produce identical architectural results.
//
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     req_valid/req_ready - request handshake
//     req_wid             - warp id
//     req_op              - 0=RW, 1=RS, 2=RC, 3=RD
//     req_addr            - 12-bit CSR address
//     req_data            - write / set / clear operand
//     req_rd              - destination register tag, returned with response
//     rsp_valid/rsp_ready - response handshake
//     rsp_wid, rsp_rd     - echoed warp id and destination tag
//     rsp_data            - old CSR value (zero on error)
//     rsp_err             - address outside the scratch range
//     pending             - per-warp "request in flight" flags
// -----------------------------------------------------------------------------
module vx_csr_pipe_unit
    import vx_csr_pkg::*;
#(
    parameter int          NUM_WARPS = 4,
    parameter int          NUM_CSRS  = 8,
    parameter logic [11:0] CSR_BASE  = 12'h7C0,
    parameter int          STAGES    = 2,
    parameter int          NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [1:0]           req_op,
    input  logic [11:0]          req_addr,
    input  logic [31:0]          req_data,
    input  logic [4:0]           req_rd,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NW_BITS-1:0]   rsp_wid,
    output logic [4:0]           rsp_rd,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,

    output logic [NUM_WARPS-1:0] pending
);

    localparam int DEPTH = NUM_WARPS * NUM_CSRS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(STAGES + 1) + 1;

    csr_entry_t pipe_q [STAGES];
    csr_entry_t pipe_d [STAGES];
    csr_entry_t acc_entry;

    logic [CNT_W-1:0] cnt_q [NUM_WARPS];
    logic [CNT_W-1:0] cnt_d [NUM_WARPS];

    csr_op_e               req_op_e;
    logic [CSR_ADDR_W-1:0] req_off;
    logic [CSR_WID_W-1:0]  req_wid_ext;
    logic                  req_in_range;
    logic                  accept;
    logic                  rsp_fire;
    logic                  rsp_stall;
    logic                  hazard_stall;
    logic [31:0]           old_sel;

    logic [IDX_W-1:0]      bank_raddr;
    logic [IDX_W-1:0]      bank_waddr;
    logic [31:0]           bank_rdata;
    logic                  bank_we;

    // ---------------- request decode ----------------
    assign req_op_e     = csr_op_e'(req_op);
    assign req_off      = req_addr - CSR_BASE;
    assign req_wid_ext  = CSR_WID_W'(req_wid);
    assign req_in_range = ({1'b0, req_addr} >= {1'b0, CSR_BASE}) &&
                          ({1'b0, req_addr} <  ({1'b0, CSR_BASE} + 13'(NUM_CSRS)));

    assign rsp_valid = pipe_q[STAGES-1].valid;
    assign rsp_stall = rsp_valid && !rsp_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign req_ready = !rsp_stall && !hazard_stall;
    assign accept    = req_valid && req_ready;

    assign bank_raddr = IDX_W'(int'(req_wid) * NUM_CSRS + int'(req_off));

    // Old-value selection. The loop walks oldest to youngest so that, when
    // forwarding, the youngest matching writer wins. The entry firing this
    // cycle is still in pipe_q, so its pending write is covered as well.
    always_comb begin
        old_sel      = bank_rdata;
        hazard_stall = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (pipe_q[i].valid && pipe_q[i].we && req_in_range &&
                (pipe_q[i].wid == req_wid_ext) &&
                (pipe_q[i].addr_idx == req_off)) begin
`ifdef CSR_PIPE_FWD_EN
                old_sel = pipe_q[i].new_val;
`else
                hazard_stall = 1'b1;
`endif
            end
        end
        if (!req_in_range) begin
            old_sel = '0;
        end
    end

    always_comb begin
        acc_entry          = '0;
        acc_entry.valid    = accept;
        acc_entry.wid      = req_wid_ext;
        acc_entry.rd       = req_rd;
        acc_entry.addr_idx = req_off;
        acc_entry.err      = !req_in_range;
        acc_entry.we       = req_in_range && csr_op_writes(req_op_e, req_data);
        acc_entry.old      = old_sel;
        acc_entry.new_val  = csr_apply_op(req_op_e, old_sel, req_data);
    end

    // ---------------- pipeline stages ----------------
    // No bubble collapsing: a stalled response holds every stage.
    always_comb begin
        pipe_d = pipe_q;
        if (!rsp_stall) begin
            pipe_d[0] = acc_entry;
            for (int i = 1; i < STAGES; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            pipe_q[i] <= pipe_d[i];
            if (reset) begin
                pipe_q[i].valid <= 1'b0;
            end
        end
    end

    // ---------------- response / commit ----------------
    assign rsp_wid  = pipe_q[STAGES-1].wid[NW_BITS-1:0];
    assign rsp_rd   = pipe_q[STAGES-1].rd;
    assign rsp_data = pipe_q[STAGES-1].old;
    assign rsp_err  = pipe_q[STAGES-1].err;

    assign bank_we    = rsp_fire && pipe_q[STAGES-1].we;
    assign bank_waddr = IDX_W'(int'(pipe_q[STAGES-1].wid) * NUM_CSRS +
                               int'(pipe_q[STAGES-1].addr_idx));

    vx_csr_bank #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (CSR_DATA_W)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .we     (bank_we),
        .waddr  (bank_waddr),
        .wdata  (pipe_q[STAGES-1].new_val),
        .raddr  (bank_raddr),
        .rdata  (bank_rdata)
    );

    // ---------------- per-warp in-flight tracking ----------------
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_d[w] = cnt_q[w];
            if ((accept && (req_wid == NW_BITS'(w))) &&
                !(rsp_fire && (rsp_wid == NW_BITS'(w)))) begin
                cnt_d[w] = cnt_q[w] + CNT_W'(1);
            end else if (!(accept && (req_wid == NW_BITS'(w))) &&
                         (rsp_fire && (rsp_wid == NW_BITS'(w)))) begin
                cnt_d[w] = cnt_q[w] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (reset) begin
                cnt_q[w] <= '0;
            end else begin
                cnt_q[w] <= cnt_d[w];
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending[w] = (cnt_q[w] != '0);
        end
    end

endmodule

// File: tb/tb_vx_csr_pipe_unit.sv
module tb_vx_csr_pipe_unit;
    import vx_csr_pkg::*;

    localparam int NW  = 4;
    localparam int NWB = 2;
    localparam int STG = 3;

`ifdef CSR_PIPE_FWD_EN
    localparam logic EXP_READY_ON_HAZARD = 1'b1;
`else
    localparam logic EXP_READY_ON_HAZARD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [NWB-1:0] req_wid;
    logic [1:0]     req_op;
    logic [11:0]    req_addr;
    logic [31:0]    req_data;
    logic [4:0]     req_rd;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [NWB-1:0] rsp_wid;
    logic [4:0]     rsp_rd;
    logic [31:0]    rsp_data;
    logic           rsp_err;
    logic [NW-1:0]  pending;

    always #5 clk = ~clk;

    vx_csr_pipe_unit #(
        .NUM_WARPS (NW),
        .NUM_CSRS  (8),
        .CSR_BASE  (12'h7C0),
        .STAGES    (STG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wid   (req_wid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_rd    (req_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wid   (rsp_wid),
        .rsp_rd    (rsp_rd),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .pending   (pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Every fired response, in order.
    logic [31:0]    log_data [$];
    logic           log_err  [$];
    logic [4:0]     log_rd   [$];
    logic [NWB-1:0] log_wid  [$];

    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            log_data.push_back(rsp_data);
            log_err.push_back(rsp_err);
            log_rd.push_back(rsp_rd);
            log_wid.push_back(rsp_wid);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [1:0] op, input logic [1:0] wid,
                           input logic [11:0] addr, input logic [31:0] data, input logic [4:0] rd);
        req_valid = v;
        req_op    = op;
        req_wid   = wid;
        req_addr  = addr;
        req_data  = data;
        req_rd    = rd;
    endtask

    // Call between a rising edge and the following falling edge.
    // Returns 1ns after the accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] wid, input logic [11:0] addr,
                         input logic [31:0] data, input logic [4:0] rd);
        bit ok = 1'b0;
        present(1'b1, op, wid, addr, data, rd);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL issue_timeout: observed no accept expected accept rd=%0d", rd);
        end
        req_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string tag, input int idx, input logic [1:0] wid,
                              input logic err, input logic [4:0] rd, input logic [31:0] data);
        for (int i = 0; i < 100 && log_data.size() <= idx; i++) begin
            @(negedge clk);
        end
        if (log_data.size() > idx) begin
            check(tag, 64'({log_wid[idx], log_err[idx], log_rd[idx], log_data[idx]}),
                  64'({wid, err, rd, data}));
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no response expected response %0d", tag, idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlog;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        present(1'b0, CSR_OP_RW, 2'd0, 12'h000, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_pending", 64'(pending), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'(1));

        // Latency: an isolated read returns exactly STG cycles after accept.
        sync();
        issue(CSR_OP_RD, 2'd3, 12'h7C1, 32'h0, 5'd7);
        @(negedge clk);
        check("lat_c1_valid", 64'(rsp_valid), 64'(0));
        check("lat_pending3", 64'(pending[3]), 64'(1));
        @(negedge clk);
        check("lat_c2_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("lat_c3_valid", 64'(rsp_valid), 64'(1));
        check("lat_c3_fields", 64'({rsp_wid, rsp_err, rsp_rd, rsp_data}),
              64'({2'd3, 1'b0, 5'd7, 32'h0}));
        expect_rsp("lat_rsp", 0, 2'd3, 1'b0, 5'd7, 32'h0);

        // RW then RD of the same CSR: read sees the write.
        sync();
        issue(CSR_OP_RW, 2'd0, 12'h7C0, 32'h1234, 5'd1);
        present(1'b0, CSR_OP_RD, 2'd0, 12'h7C0, 32'h0, 5'd2);
        @(negedge clk);
        check("raw_ready", 64'(req_ready), 64'(EXP_READY_ON_HAZARD));
        check("raw_pending0", 64'(pending[0]), 64'(1));
        sync();
        issue(CSR_OP_RD, 2'd0, 12'h7C0, 32'h0, 5'd2);
        expect_rsp("raw_rw", 1, 2'd0, 1'b0, 5'd1, 32'h0);
        expect_rsp("raw_rd", 2, 2'd0, 1'b0, 5'd2, 32'h1234);

        // Set, clear, read back-to-back on 0x7C2.
        sync();
        issue(CSR_OP_RS, 2'd0, 12'h7C2, 32'h00F0, 5'd3);
        issue(CSR_OP_RC, 2'd0, 12'h7C2, 32'h0030, 5'd4);
        issue(CSR_OP_RD, 2'd0, 12'h7C2, 32'h0, 5'd5);
        expect_rsp("rs_old", 3, 2'd0, 1'b0, 5'd3, 32'h0);
        expect_rsp("rc_old", 4, 2'd0, 1'b0, 5'd4, 32'h00F0);
        expect_rsp("rd_after_rc", 5, 2'd0, 1'b0, 5'd5, 32'h00C0);

        // RS with zero mask, out-of-range addresses.
        sync();
        issue(CSR_OP_RW, 2'd0, 12'h7C3, 32'hAA, 5'd6);
        issue(CSR_OP_RS, 2'd0, 12'h7C3, 32'h0, 5'd7);
        issue(CSR_OP_RD, 2'd0, 12'h7C3, 32'h0, 5'd8);
        issue(CSR_OP_RW, 2'd0, 12'h7C8, 32'hDEAD, 5'd9);
        issue(CSR_OP_RD, 2'd0, 12'h7BF, 32'h0, 5'd10);
        issue(CSR_OP_RD, 2'd1, 12'h7C0, 32'h0, 5'd11);
        expect_rsp("rw_aa", 6, 2'd0, 1'b0, 5'd6, 32'h0);
        expect_rsp("rs_zero", 7, 2'd0, 1'b0, 5'd7, 32'hAA);
        expect_rsp("rd_unchanged", 8, 2'd0, 1'b0, 5'd8, 32'hAA);
        expect_rsp("err_high", 9, 2'd0, 1'b1, 5'd9, 32'h0);
        expect_rsp("err_low", 10, 2'd0, 1'b1, 5'd10, 32'h0);
        expect_rsp("err_no_alias", 11, 2'd1, 1'b0, 5'd11, 32'h0);

        // Two warps, same address: no cross-warp interaction.
        sync();
        issue(CSR_OP_RW, 2'd0, 12'h7C5, 32'h11, 5'd12);
        present(1'b0, CSR_OP_RW, 2'd1, 12'h7C5, 32'h22, 5'd13);
        @(negedge clk);
        check("xwarp_ready", 64'(req_ready), 64'(1));
        sync();
        issue(CSR_OP_RW, 2'd1, 12'h7C5, 32'h22, 5'd13);
        issue(CSR_OP_RD, 2'd0, 12'h7C5, 32'h0, 5'd14);
        issue(CSR_OP_RD, 2'd1, 12'h7C5, 32'h0, 5'd15);
        expect_rsp("xwarp_w0_rw", 12, 2'd0, 1'b0, 5'd12, 32'h0);
        expect_rsp("xwarp_w1_rw", 13, 2'd1, 1'b0, 5'd13, 32'h0);
        expect_rsp("xwarp_w0_rd", 14, 2'd0, 1'b0, 5'd14, 32'h11);
        expect_rsp("xwarp_w1_rd", 15, 2'd1, 1'b0, 5'd15, 32'h22);

        // Backpressure: three reads in flight, response held for 5 cycles.
        sync();
        rsp_ready = 1'b0;
        issue(CSR_OP_RD, 2'd0, 12'h7C0, 32'h0, 5'd16);
        issue(CSR_OP_RD, 2'd0, 12'h7C2, 32'h0, 5'd17);
        issue(CSR_OP_RD, 2'd0, 12'h7C5, 32'h0, 5'd18);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_ready", 64'(req_ready), 64'(0));
            check("bp_hold_rsp", 64'({rsp_valid, rsp_rd, rsp_data}),
                  64'({1'b1, 5'd16, 32'h1234}));
            check("bp_hold_pending", 64'(pending[0]), 64'(1));
        end
        sync();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_1", 64'({rsp_valid, rsp_rd, rsp_data}), 64'({1'b1, 5'd16, 32'h1234}));
        @(negedge clk);
        check("bp_rel_2", 64'({rsp_valid, rsp_rd, rsp_data}), 64'({1'b1, 5'd17, 32'h00C0}));
        @(negedge clk);
        check("bp_rel_3", 64'({rsp_valid, rsp_rd, rsp_data}), 64'({1'b1, 5'd18, 32'h11}));
        check("bp_pending_before_last", 64'(pending[0]), 64'(1));
        @(negedge clk);
        check("bp_drained", 64'(rsp_valid), 64'(0));
        check("bp_pending_clear", 64'(pending[0]), 64'(0));
        check("bp_count", 64'(log_data.size()), 64'(19));

        // Reset with two writes in flight.
        sync();
        issue(CSR_OP_RW, 2'd2, 12'h7C4, 32'h55, 5'd19);
        issue(CSR_OP_RW, 2'd2, 12'h7C6, 32'h66, 5'd20);
        reset = 1'b1;
        nlog = log_data.size();
        @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_no_rsp", 64'(log_data.size()), 64'(nlog));
        sync();
        issue(CSR_OP_RD, 2'd2, 12'h7C4, 32'h0, 5'd21);
        issue(CSR_OP_RD, 2'd2, 12'h7C6, 32'h0, 5'd22);
        issue(CSR_OP_RD, 2'd0, 12'h7C0, 32'h0, 5'd23);
        expect_rsp("rst_w2_c4", nlog,     2'd2, 1'b0, 5'd21, 32'h0);
        expect_rsp("rst_w2_c6", nlog + 1, 2'd2, 1'b0, 5'd22, 32'h0);
        expect_rsp("rst_w0_c0", nlog + 2, 2'd0, 1'b0, 5'd23, 32'h0);
        @(negedge clk);
        check("end_pending", 64'(pending), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
